// File: rtl/transfer_shift_pkg.sv
// Shared definitions for the transfer-and-shift datapath: FSM encodings and default sizes
// used by the operand loader and the downstream shift stage.
package transfer_shift_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam int DEFAULT_WIDTH = 4;
    localparam int PAIR_CNT_W    = 8;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_A = ST_LOAD_A,
        LOAD_B = ST_LOAD_B,
        ISSUE  = ST_ISSUE,
        HOLD   = ST_HOLD
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in/parallel-out shift register; the first bit received ends up at the MSB when
// MSB_FIRST is set, at the LSB otherwise.
module serial_shift_reg
    import transfer_shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else if (en) begin
            if (MSB_FIRST != 0) sr_q <= {sr_q[WIDTH-2:0], din};
            else                sr_q <= {din, sr_q[WIDTH-1:1]};
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/operand_pair_loader.sv
// Assembles operand A then operand B from a gapped serial stream, issues them to the shift
// stage with a one-cycle start pulse and holds them stable for HOLD_CYCLES afterwards.
module operand_pair_loader
    import transfer_shift_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    input  logic                  abort,
    input  logic                  clear_ovr,
    output logic [WIDTH-1:0]      A_out,
    output logic [WIDTH-1:0]      B_out,
    output logic                  start,
    output logic                  busy,
    output logic                  overrun,
    output logic [PAIR_CNT_W-1:0] pair_count
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [HCNT_W-1:0] LAST_HOLD = HCNT_W'(HOLD_CYCLES - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [HCNT_W-1:0]       hold_cnt_q;
    logic [WIDTH-1:0]        a_stage_q;
    logic [WIDTH-1:0]        a_out_q;
    logic [WIDTH-1:0]        b_out_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    ovr_q;
    logic [PAIR_CNT_W-1:0]   pair_cnt_q;

    logic             loading;
    logic             committed;
    logic             sr_en;
    logic             sr_clr;
    logic             drop;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // The completed operand must include the bit arriving on this edge, so capture the
    // shift register's next value rather than its current contents.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST != 0) return {cur[WIDTH-2:0], b};
        else                return {b, cur[WIDTH-1:1]};
    endfunction

    assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign committed = (state_q == ISSUE) || (state_q == HOLD);
    assign sr_en     = serial_valid && !abort && (loading || state_q == IDLE);
    assign sr_clr    = abort && loading;
    assign drop      = serial_valid && committed;
    assign sr_d      = shift_in(sr_q, serial_in);

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (sr_clr),
        .en      (sr_en),
        .din     (serial_in),
        .q       (sr_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            a_stage_q  <= '0;
            a_out_q    <= '0;
            b_out_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            pair_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            if (drop)           ovr_q <= 1'b1;
            else if (clear_ovr) ovr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (serial_valid && !abort) begin
                        bit_cnt_q <= CNT_W'(1);
                        state_q   <= LOAD_A;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (abort) begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if (serial_valid) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (state_q == LOAD_A) begin
                                a_stage_q <= sr_d;
                                state_q   <= LOAD_B;
                            end else begin
                                a_out_q    <= a_stage_q;
                                b_out_q    <= sr_d;
                                start_q    <= 1'b1;
                                pair_cnt_q <= pair_cnt_q + 1'b1;
                                state_q    <= ISSUE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    hold_cnt_q <= '0;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt_q == LAST_HOLD) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A_out      = a_out_q;
    assign B_out      = b_out_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign pair_count = pair_cnt_q;

endmodule

// File: tb/tb_operand_pair_loader.sv
// Bench for operand_pair_loader: an MSB-first and an LSB-first instance share one stimulus
// stream and are compared every cycle against a bit-queue reference model.
module tb_operand_pair_loader;

    localparam int W    = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic serial_in = 1'b0, serial_valid = 1'b0, abort = 1'b0, clear_ovr = 1'b0;
    logic [W-1:0] a0, b0, a1, b1;
    logic start0, start1, busy0, busy1, ovr0, ovr1;
    logic [7:0] cnt0, cnt1;

    always #5 clk = ~clk;

    operand_pair_loader #(.WIDTH(W), .HOLD_CYCLES(HOLD), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_valid(serial_valid),
        .abort(abort), .clear_ovr(clear_ovr), .A_out(a0), .B_out(b0), .start(start0),
        .busy(busy0), .overrun(ovr0), .pair_count(cnt0));

    operand_pair_loader #(.WIDTH(W), .HOLD_CYCLES(HOLD), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_valid(serial_valid),
        .abort(abort), .clear_ovr(clear_ovr), .A_out(a1), .B_out(b1), .start(start1),
        .busy(busy1), .overrun(ovr1), .pair_count(cnt1));

    int checks = 0;
    int errors = 0;

    // Reference model: received bits of the pending pair, cycles left until busy drops.
    bit q[$];
    int m_hold;
    int m_a_msb, m_b_msb, m_a_lsb, m_b_lsb, m_cnt;
    bit m_start, m_busy, m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_hold = 0; m_cnt = 0;
        m_a_msb = 0; m_b_msb = 0; m_a_lsb = 0; m_b_lsb = 0;
        m_start = 0; m_busy = 0; m_ovr = 0;
    endfunction

    function automatic void model_edge(bit sv, bit din, bit ab, bit clr);
        m_start = 0;
        if (m_hold > 0) begin
            if (sv) m_ovr = 1; else if (clr) m_ovr = 0;
            m_hold--;
            if (m_hold == 0) m_busy = 0;
        end else begin
            if (clr) m_ovr = 0;
            if (ab) begin
                q.delete();
                m_busy = 0;
            end else if (sv) begin
                q.push_back(din);
                m_busy = 1;
                if (q.size() == 2 * W) begin
                    m_a_msb = 0; m_b_msb = 0; m_a_lsb = 0; m_b_lsb = 0;
                    for (int i = 0; i < W; i++) begin
                        m_a_msb += int'(q[i])     * (1 << (W - 1 - i));
                        m_b_msb += int'(q[W + i]) * (1 << (W - 1 - i));
                        m_a_lsb += int'(q[i])     * (1 << i);
                        m_b_lsb += int'(q[W + i]) * (1 << i);
                    end
                    m_cnt   = (m_cnt + 1) % 256;
                    m_start = 1;
                    m_hold  = HOLD + 1;
                    q.delete();
                end
            end
        end
    endfunction

    task automatic compare_all();
        chk("A_msb", 32'(a0), 32'(m_a_msb));
        chk("B_msb", 32'(b0), 32'(m_b_msb));
        chk("A_lsb", 32'(a1), 32'(m_a_lsb));
        chk("B_lsb", 32'(b1), 32'(m_b_lsb));
        chk("start_msb", 32'(start0), 32'(m_start));
        chk("start_lsb", 32'(start1), 32'(m_start));
        chk("busy_msb", 32'(busy0), 32'(m_busy));
        chk("busy_lsb", 32'(busy1), 32'(m_busy));
        chk("ovr_msb", 32'(ovr0), 32'(m_ovr));
        chk("ovr_lsb", 32'(ovr1), 32'(m_ovr));
        chk("cnt_msb", 32'(cnt0), 32'(m_cnt));
        chk("cnt_lsb", 32'(cnt1), 32'(m_cnt));
    endtask

    task automatic step(input bit sv, input bit din, input bit ab, input bit clr);
        serial_valid = sv; serial_in = din; abort = ab; clear_ovr = clr;
        @(posedge clk);
        model_edge(sv, din, ab, clr);
        #1;
        compare_all();
        serial_valid = 1'b0; abort = 1'b0; clear_ovr = 1'b0;
    endtask

    // Sends bits MSB of the vector first; maxgap>0 inserts 1..maxgap idle cycles between bits.
    task automatic send_bits(input logic [7:0] bits, input int nbits, input int maxgap);
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, bits[7 - i], 1'b0, 1'b0);
            if (maxgap > 0 && i < nbits - 1)
                repeat ($urandom_range(1, maxgap)) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && m_busy; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_bound", 32'(busy0), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_A"}, 32'({a0, b0, a1, b1}), 32'd0);
        chk({tag, "_flags"}, 32'({start0, busy0, ovr0, start1, busy1, ovr1}), 32'd0);
        chk({tag, "_cnt"}, 32'({cnt0, cnt1}), 32'd0);
    endtask

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge clk) reset_n = 1'b1;

        // Directed pair, back to back
        send_bits(8'b0010_0101, 8, 0);
        chk("t1_A", 32'(a0), 32'h2);
        chk("t1_B", 32'(b0), 32'h5);
        chk("t1_start", 32'(start0), 32'd1);
        chk("t1_cnt", 32'(cnt0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_start_low", 32'(start0), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_hold", 32'(busy0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_low", 32'(busy0), 32'd0);

        // Same pair with gaps between bits
        send_bits(8'b0010_0101, 8, 3);
        chk("t2_A", 32'(a0), 32'h2);
        chk("t2_B", 32'(b0), 32'h5);
        chk("t2_start", 32'(start0), 32'd1);
        wait_idle();

        // Drop during HOLD, then clear; then drop and clear on the same edge
        send_bits(8'b1100_0011, 8, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_ovr", 32'(ovr0), 32'd1);
        chk("t3_A_kept", 32'(a0), 32'hC);
        chk("t3_B_kept", 32'(b0), 32'h3);
        wait_idle();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovr_clr", 32'(ovr0), 32'd0);
        send_bits(8'b1010_1010, 8, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_ovr_sticky", 32'(ovr0), 32'd1);
        wait_idle();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort after five bits
        send_bits(8'b1111_1000, 5, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_busy", 32'(busy0), 32'd0);
        chk("t4_start", 32'(start0), 32'd0);
        send_bits(8'b0101_0010, 8, 0);
        chk("t4_A", 32'(a0), 32'h5);
        chk("t4_B", 32'(b0), 32'h2);
        wait_idle();

        // Asynchronous reset mid-pair, then counter wrap
        send_bits(8'b1011_0100, 6, 0);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check_all_zero("t5_reset");
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        for (int p = 0; p < 256; p++) begin
            send_bits(8'($urandom), 8, 0);
            wait_idle();
        end
        chk("t5_wrap_msb", 32'(cnt0), 32'd0);
        chk("t5_wrap_lsb", 32'(cnt1), 32'd0);

        // LSB-first assembly
        send_bits(8'b0100_1010, 8, 0);
        chk("t6_A", 32'(a1), 32'h2);
        chk("t6_B", 32'(b1), 32'h5);
        wait_idle();

        // Random traffic with aborts, drops and clears
        for (int c = 0; c < 600; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
